// File: rtl/ram_arb_pkg.sv
// Shared constants and types for the two-port RAM arbiter.
package ram_arb_pkg;

  localparam logic PORT_CPU    = 1'b0;
  localparam logic PORT_LOADER = 1'b1;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 9;
  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

  // Travels alongside a read so its data is handed only to the issuing port.
  typedef struct packed {
    logic valid;
    logic owner;
  } read_tag_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way request picker: round-robin on contention, or port 0 always wins
// when FIXED_PRIORITY is set. Purely combinational.
module rr_arbiter2 #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic [1:0] i_req,
  input  logic       i_lastGrant,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    unique case (i_req)
      2'b01: o_grant = 2'b01;
      2'b10: o_grant = 2'b10;
      // On a tie the port that did not win last time goes next.
      2'b11: begin
        if (FIXED_PRIORITY) o_grant = 2'b01;
        else                o_grant = i_lastGrant ? 2'b01 : 2'b10;
      end
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares a single-port RAM between the CPU bus (port 0) and the loader
// (port 1); RAM controls are registered and reads are tagged by owner.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter bit          FIXED_PRIORITY = 1'b0
) (
  input  logic                  raw_clk,
  input  logic                  reset_n,

  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_address,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_ack,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  output logic                  p0_rvalid,

  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_address,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_ack,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  p1_rvalid,

  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_write_enable,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  logic [1:0]            w_grant;
  logic                  w_any;
  logic                  w_sel;
  logic                  w_selWe;
  logic [ADDR_WIDTH-1:0] w_selAddr;
  logic [DATA_WIDTH-1:0] w_selWdata;

  logic                  r_lastGrant;
  logic [ADDR_WIDTH-1:0] r_ramAddress;
  logic [DATA_WIDTH-1:0] r_ramDataIn;
  logic                  r_ramWe;
  read_tag_t             r_tag1;
  read_tag_t             r_tag2;

  rr_arbiter2 #(
    .FIXED_PRIORITY(FIXED_PRIORITY)
  ) u_pick (
    .i_req      ({p1_req, p0_req}),
    .i_lastGrant(r_lastGrant),
    .o_grant    (w_grant)
  );

  always_comb begin
    w_any      = |w_grant;
    w_sel      = w_grant[1];
    w_selWe    = w_sel ? p1_we      : p0_we;
    w_selAddr  = w_sel ? p1_address : p0_address;
    w_selWdata = w_sel ? p1_wdata   : p0_wdata;
  end

  // Write enable drops on idle cycles so the RAM never repeats a write;
  // address and data simply hold.
  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lastGrant  <= PORT_LOADER;
      r_ramAddress <= '0;
      r_ramDataIn  <= '0;
      r_ramWe      <= 1'b0;
      r_tag1       <= '0;
      r_tag2       <= '0;
    end else begin
      if (w_any) begin
        r_lastGrant  <= w_sel;
        r_ramAddress <= w_selAddr;
        r_ramDataIn  <= w_selWdata;
        r_ramWe      <= w_selWe;
      end else begin
        r_ramWe      <= 1'b0;
      end
      r_tag1 <= '{valid: w_any && !w_selWe, owner: w_sel};
      r_tag2 <= r_tag1;
    end
  end

  assign p0_ack           = w_grant[0];
  assign p1_ack           = w_grant[1];
  assign ram_address      = r_ramAddress;
  assign ram_data_in      = r_ramDataIn;
  assign ram_write_enable = r_ramWe;
  assign p0_rdata         = ram_data_out;
  assign p1_rdata         = ram_data_out;
  assign p0_rvalid        = r_tag2.valid && (r_tag2.owner == PORT_CPU);
  assign p1_rvalid        = r_tag2.valid && (r_tag2.owner == PORT_LOADER);

endmodule
